muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers, alongside the ALU in the Execute stage of the pipelined core.
- Adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support; MFHI/MFLO read hi/lo directly.
- Multi-cycle ops assert busy; the hazard unit stalls F/D and flushes E on it.
- Parametrised in datapath width and bits retired per cycle.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the Execute stage.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle one.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int N  = WIDTH / STEP;
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    typedef enum logic [2:0] {
        OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV  = 3'b010,
        OP_DIVU = 3'b011, OP_MTHI  = 3'b100, OP_MTLO = 3'b101
    } op_t;

    state_t           state_q;
    logic [W2-1:0]    acc_q;     // MUL: {partial sum, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0] opnd_q;    // multiplicand or divisor magnitude
    logic [CW-1:0]    cnt_q;
    logic             neg_q, rneg_q, dz_q, is_mul_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    // Operand magnitudes and signs, only meaningful while issuing from IDLE.
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

`ifndef MULDIV_FAST_MUL_EN
    logic [WIDTH+STEP-1:0] mul_sum;
    logic [W2-1:0]         mul_d;

    always_comb begin
        mul_sum = (WIDTH+STEP)'(acc_q[W2-1:WIDTH])
                + (WIDTH+STEP)'(opnd_q) * (WIDTH+STEP)'(acc_q[STEP-1:0]);
        mul_d   = W2'({mul_sum, acc_q[WIDTH-1:0]} >> STEP);
    end
`endif

    // Restoring division, STEP quotient bits per cycle.
    logic [WIDTH:0]   div_r;
    logic [WIDTH-1:0] div_rw, div_qw;
    logic [W2-1:0]    div_d;

    always_comb begin
        // NOTE: every variable gets a value before the loop so no latch is inferred.
        div_r  = '0;
        div_rw = acc_q[W2-1:WIDTH];
        div_qw = acc_q[WIDTH-1:0];
        for (int i = 0; i < STEP; i++) begin
            div_r  = {div_rw, div_qw[WIDTH-1]};
            div_qw = {div_qw[WIDTH-2:0], 1'b0};
            if (div_r >= {1'b0, opnd_q}) begin
                div_r     = div_r - {1'b0, opnd_q};
                div_qw[0] = 1'b1;
            end
            div_rw = div_r[WIDTH-1:0];
        end
        div_d = {div_rw, div_qw};
    end

    logic [W2-1:0]    prod_src, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod_src = W2'(opnd_q) * W2'(acc_q[WIDTH-1:0]);
`else
        prod_src = acc_q;
`endif
        prod_fix = neg_q ? -prod_src : prod_src;
        quo_fix  = dz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix  = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    end

    // NOTE: sequential state is updated with <= only, so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            is_mul_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (kill) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state_q  <= S_MUL;
                                busy_q   <= 1'b1;
                                is_mul_q <= 1'b1;
                                opnd_q   <= a_mag;
                                acc_q    <= W2'(b_mag);
                                neg_q    <= a_neg ^ b_neg;
                                rneg_q   <= 1'b0;
                                dz_q     <= 1'b0;
                                cnt_q    <= '0;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_q  <= S_DIV;
                                busy_q   <= 1'b1;
                                is_mul_q <= 1'b0;
                                opnd_q   <= b_mag;
                                acc_q    <= W2'(a_mag);
                                neg_q    <= a_neg ^ b_neg;
                                rneg_q   <= a_neg;
                                dz_q     <= (b == '0);
                                cnt_q    <= '0;
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                    S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                        {hi_q, lo_q} <= prod_fix;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
`else
                        acc_q <= mul_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) state_q <= S_FIX;
`endif
                    end
                    S_DIV: begin
                        acc_q <= div_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) state_q <= S_FIX;
                    end
                    S_FIX: begin
                        if (is_mul_q) begin
                            {hi_q, lo_q} <= prod_fix;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32, STEP=1).
module tb_muldiv_unit;
    localparam int W       = 32;
    localparam int N       = 32;
    localparam int DIV_LAT = N + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int          MUL_LAT = 1;
    localparam logic [2:0]  KILL_OP = 3'b011;
`else
    localparam int          MUL_LAT = N + 1;
    localparam logic [2:0]  KILL_OP = 3'b001;
`endif
    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, ILLEGAL = 3'b110;

    logic         clk = 1'b0;
    logic         reset, start, kill, busy, done;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    int           n_checks = 0;
    int           n_pass   = 0;
    logic         seen_done;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .STEP(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .kill(kill), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        a     = '0;
        b     = '0;
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int lat);
        int cycles;
        issue(o, x, y);
        check({tag, "_busy_on_issue"}, busy, 1);
        cycles = 0;
        while (!done && cycles < 100) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, lat);
        check({tag, "_busy_at_done"}, busy, 0);
        tick();
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        tick(); tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        reset = 1'b0;
        tick();

        run("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);

        run("mult_neg", MULT, 32'hFFFF_FFFD, 32'h0000_0007, MUL_LAT);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);

        run("div_neg", DIV, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        run("divu_zero", DIVU, 32'h0000_0064, 32'h0000_0000, DIV_LAT);
        check("divu_zero_lo", lo, 32'hFFFF_FFFF);
        check("divu_zero_hi", hi, 32'h0000_0064);

        run("div_zero", DIV, 32'hFFFF_FFF9, 32'h0000_0000, DIV_LAT);
        check("div_zero_lo", lo, 32'hFFFF_FFFF);
        check("div_zero_hi", hi, 32'hFFFF_FFF9);

        run("divu_rem", DIVU, 32'd100, 32'd7, DIV_LAT);
        check("divu_rem_lo", lo, 32'd14);
        check("divu_rem_hi", hi, 32'd2);

        run("div_negdiv", DIV, 32'd7, 32'hFFFF_FFFE, DIV_LAT);
        check("div_negdiv_lo", lo, 32'hFFFF_FFFD);
        check("div_negdiv_hi", hi, 32'd1);

        // Move-to registers, then an aborted op with an ignored issue mid-flight.
        issue(MTLO, 32'h0000_0000, '0);
        check("mtlo_lo", lo, 0);
        issue(MTHI, 32'h1234_5678, '0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", busy, 0);
        check("mthi_done", done, 0);

        issue(KILL_OP, 32'd5, 32'd6);
        check("kill_busy_on_issue", busy, 1);
        tick(); tick();
        issue(MTHI, 32'hDEAD_BEEF, '0);
        check("busy_start_ignored_busy", busy, 1);
        check("busy_start_ignored_hi", hi, 32'h1234_5678);
        repeat (6) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_busy", busy, 0);
        seen_done = done;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen_done |= done;
        end
        check("kill_no_done", seen_done, 0);
        check("kill_hi", hi, 32'h1234_5678);
        check("kill_lo", lo, 32'h0000_0000);

        // Kill wins over a same-cycle issue.
        kill = 1'b1;
        issue(MTHI, 32'h0000_0001, '0);
        issue(MULTU, 32'd3, 32'd4);
        kill = 1'b0;
        check("kill_start_busy", busy, 0);
        check("kill_start_hi", hi, 32'h1234_5678);

        issue(ILLEGAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("illegal_busy", busy, 0);
        check("illegal_hi", hi, 32'h1234_5678);
        check("illegal_lo", lo, 32'h0000_0000);
        tick();
        check("illegal_done", done, 0);

        // Asynchronous reset in the middle of a divide.
        issue(MTLO, 32'hAAAA_5555, '0);
        check("mtlo2_lo", lo, 32'hAAAA_5555);
        issue(DIV, 32'd1000, 32'd3);
        repeat (20) tick();
        check("pre_reset_busy", busy, 1);
        #3 reset = 1'b1;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_done", done, 0);
        check("async_reset_hi", hi, 0);
        check("async_reset_lo", lo, 0);
        tick();
        reset = 1'b0;
        tick();

        run("multu_small", MULTU, 32'd3, 32'd4, MUL_LAT);
        check("multu_small_lo", lo, 32'h0000_000C);
        check("multu_small_hi", hi, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
